// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns single-beat valid/ready commands into APB4 setup/access transfers, one outstanding.
// Optional build macro APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYC cycles without pready.
module apb_cmd_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic                  m_pwrite,
  output logic [ADDR_W-1:0]     m_paddr,
  output logic [DATA_W-1:0]     m_pwdata,
  output logic [DATA_W/8-1:0]   m_pstrb,
  input  logic                  m_pready,
  input  logic [DATA_W-1:0]     m_prdata,
  input  logic                  m_pslverr
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic                cmd_ready_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                psel_reg;
  logic                penable_reg;
  logic                pwrite_reg;
  logic [ADDR_W-1:0]   paddr_reg;
  logic [DATA_W-1:0]   pwdata_reg;
  logic [STRB_W-1:0]   pstrb_reg;
  logic [STRB_W-1:0]   strb_next;
  logic [DATA_W-1:0]   wdata_next;

  // Reads must present all-zero strobes, so each lane is gated by direction.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb_lane
      assign strb_next[gi] = cmd_write & cmd_strb[gi];
    end
  endgenerate

  assign wdata_next = cmd_write ? cmd_wdata : '0;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_reg;
  logic       rsp_timeout_reg;
  assign rsp_timeout = rsp_timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign rsp_timeout        = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_reg    <= 8'd0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            psel_reg      <= 1'b1;
            pwrite_reg    <= cmd_write;
            paddr_reg     <= cmd_addr;
            pwdata_reg    <= wdata_next;
            pstrb_reg     <= strb_next;
            cmd_ready_reg <= 1'b0;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_reg <= 8'd0;
`endif
        end
        ACCESS: begin
          if (m_pready) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= pwrite_reg ? '0 : m_prdata;
            rsp_err_reg   <= m_pslverr;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            state_reg     <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          // This is the TIMEOUT_CYC-th cycle without pready: give up on the slave.
          else if (wait_cnt_reg == TIMEOUT_LAST) begin
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pstrb_reg       <= '0;
            state_reg       <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign m_psel    = psel_reg;
  assign m_penable = penable_reg;
  assign m_pwrite  = pwrite_reg;
  assign m_paddr   = paddr_reg;
  assign m_pwdata  = pwdata_reg;
  assign m_pstrb   = pstrb_reg;

endmodule
